// File: rtl/systolic_feed_controller.sv
// Feeds a chain of weight_comp_cell instances one vector at a time and collects
// the flagged results leaving the last cell into a credit-protected result FIFO.
module systolic_feed_controller #(
  parameter int DATA_WIDTH    = 8,
  parameter int RESULT_WIDTH  = 16,
  parameter int INDEX_WIDTH   = 10,
  parameter int WEIGHT_AMOUNT = 4,
  parameter int CELL_COUNT    = 4,
  parameter int RESULT_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   array_value,
  output logic [INDEX_WIDTH-1:0]  array_index,
  output logic                    array_enable,
  input  logic [RESULT_WIDTH:0]   array_result,
  output logic [RESULT_WIDTH-1:0] out_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    error
);

  localparam int IDX_W = (WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1;
  localparam int CNT_W = $clog2(RESULT_DEPTH + 1);
  localparam int SPC_W = (CELL_COUNT > 1) ? $clog2(CELL_COUNT) : 1;
  localparam int PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int SUM_W = CNT_W + 2;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WEIGHT_AMOUNT - 1);
  localparam logic [CNT_W-1:0] CNT_CELLS = CNT_W'(CELL_COUNT);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(RESULT_DEPTH);
  localparam logic [SPC_W-1:0] SPC_LOAD  = SPC_W'(CELL_COUNT - 1);
  localparam logic [SUM_W-1:0] SUM_DEPTH = SUM_W'(RESULT_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FEED = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic [CNT_W-1:0]        pending;
  logic [CNT_W-1:0]        pending_nxt;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        fifo_count_nxt;
  logic [SPC_W-1:0]        spacing;
  logic [SPC_W-1:0]        spacing_nxt;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [RESULT_WIDTH-1:0] mem [RESULT_DEPTH];
  logic [SUM_W-1:0]        credit_sum;
  logic                    start_ok;
  logic                    accept;
  logic                    first_accept;
  logic                    last_accept;
  logic                    result_flag;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;
  logic                    drop;

  // Credit check: every result the chain may still produce must fit in the FIFO.
  assign credit_sum   = SUM_W'(fifo_count) + SUM_W'(pending) + SUM_W'(CNT_CELLS);
  assign start_ok     = (spacing == '0) && (credit_sum <= SUM_DEPTH);
  assign in_ready     = !rst && ((state == FEED) || ((state == IDLE) && start_ok));
  assign accept       = in_valid && in_ready;
  assign first_accept = accept && (state == IDLE);
  assign last_accept  = accept && (idx == IDX_LAST);

  assign result_flag  = array_result[RESULT_WIDTH];
  assign fifo_full    = (fifo_count == CNT_DEPTH);
  assign out_valid    = (fifo_count != '0);
  assign pop          = out_valid && out_ready;
  assign push         = result_flag && (pending != '0) && (!fifo_full || pop);
  assign drop         = result_flag && !push;

  assign out_result   = out_valid ? mem[rd_ptr] : '0;
  assign busy         = (state == FEED) || (pending != '0) || (fifo_count != '0);

  // Next-state logic; a single-element vector never leaves IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (first_accept && !last_accept) begin
          state_nxt = FEED;
        end else begin
          state_nxt = IDLE;
        end
      end
      FEED: begin
        if (last_accept) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = FEED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Element index and start spacing counters.
  always_comb begin
    idx_nxt     = idx;
    spacing_nxt = spacing;
    if (accept) begin
      idx_nxt = last_accept ? '0 : (idx + IDX_W'(1));
    end else begin
      idx_nxt = idx;
    end
    if (first_accept) begin
      spacing_nxt = SPC_LOAD;
    end else if (spacing != '0) begin
      spacing_nxt = spacing - SPC_W'(1);
    end else begin
      spacing_nxt = spacing;
    end
  end

  // Outstanding-result credit and FIFO occupancy bookkeeping.
  always_comb begin
    pending_nxt    = pending;
    fifo_count_nxt = fifo_count;
    if (first_accept) begin
      pending_nxt = pending_nxt + CNT_CELLS;
    end else begin
      pending_nxt = pending_nxt;
    end
    if (result_flag && (pending != '0)) begin
      pending_nxt = pending_nxt - CNT_W'(1);
    end else begin
      pending_nxt = pending_nxt;
    end
    case ({push, pop})
      2'b10:   fifo_count_nxt = fifo_count + CNT_W'(1);
      2'b01:   fifo_count_nxt = fifo_count - CNT_W'(1);
      default: fifo_count_nxt = fifo_count;
    endcase
  end

  // Control state, counters and the registered array drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      pending      <= '0;
      spacing      <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      error        <= 1'b0;
      array_value  <= '0;
      array_index  <= '0;
      array_enable <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pending    <= pending_nxt;
      spacing    <= spacing_nxt;
      fifo_count <= fifo_count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop) begin
        error <= 1'b1;
      end
      if (accept) begin
        array_value  <= in_data;
        array_index  <= INDEX_WIDTH'(idx);
        array_enable <= 1'b1;
      end else begin
        array_value  <= '0;
        array_index  <= '0;
        array_enable <= 1'b0;
      end
    end
  end

  // Result storage; contents need no reset because out_result is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= array_result[RESULT_WIDTH-1:0];
    end
  end

endmodule

// File: doc/systolic_feed_controller.md
# systolic_feed_controller

Sequencer for a chain of `weight_comp_cell` instances. It accepts a stream of input elements and drives cell 0 with value/index/enable beats, WEIGHT_AMOUNT elements per vector. It collects the flagged results leaving the last cell into a result FIFO and presents them on a valid/ready output. It throttles vector starts with a credit scheme, so every result the chain can produce always has FIFO space.

## Interface
Parameters:
- DATA_WIDTH, 8, element width
- RESULT_WIDTH, 16, result width; result bus carries one extra flag bit
- INDEX_WIDTH, 10, index bus width
- WEIGHT_AMOUNT, 4, elements per vector (W)
- CELL_COUNT, 4, cells in chain = results per vector (C)
- RESULT_DEPTH, 8, result FIFO depth; power of two, must be >= CELL_COUNT

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH  element value
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when in_valid && in_ready
- array_value  out  DATA_WIDTH  to cell 0 input_value
- array_index  out  INDEX_WIDTH  to cell 0 input_index
- array_enable  out  1  to cell 0 input_enable
- array_result  in  RESULT_WIDTH+1  from last cell output_result; bit RESULT_WIDTH is the valid flag
- out_result  out  RESULT_WIDTH  result data (FIFO head)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  pop when out_valid && out_ready
- busy  out  1  feeding, results pending, or FIFO non-empty
- error  out  1  sticky: result dropped

Cell 0 input_result is tied to 0 at the integration level.

## Operation
- State machine, two states:
  - IDLE: waiting to start a vector.
  - FEED: elements 1..W-1 of the current vector.
- IDLE → FEED: on acceptance of element 0. The start condition is `start_ok` = (spacing == 0) && (fifo_count + pending + C <= RESULT_DEPTH).
- FEED → IDLE: on acceptance of element W-1. If W == 1, the controller stays in IDLE.
- in_ready = !rst && (state == FEED || (state == IDLE && start_ok)).
- Element counter `idx`:
  - 0 in IDLE.
  - Increments per accepted element.
  - Wraps to 0 after W-1.
- Array drive, registered:
  - On the accept cycle, the next edge loads array_value = in_data, array_index = idx, array_enable = 1.
  - Otherwise the next edge loads array_value = 0, array_index = 0, array_enable = 0.
  - If in_valid drops mid-vector, the controller stays in FEED, enable drops, and the index resumes where it left off on the next accept.
- `pending` counter (width to hold RESULT_DEPTH):
  - +C on acceptance of element 0.
  - −1 per arriving flagged result.
  - Both in the same cycle: net C−1.
- `spacing` counter:
  - Loaded with C−1 on acceptance of element 0.
  - Decrements to 0 each cycle.
  - Guarantees at least C cycles between consecutive index-0 beats. This prevents result collisions inside the cells' one-deep result buffers.
- Result capture:
  - When array_result[RESULT_WIDTH] == 1 and pending != 0, push array_result[RESULT_WIDTH-1:0] into the FIFO.
  - Results emerge in cell order: cell 0 first, then cell C−1 last.
  - If pending == 0, or the FIFO is full and not popping that cycle, the result is dropped and error is set. error stays set until rst.
- FIFO:
  - Synchronous, registered head, no fall-through.
  - Simultaneous push and pop when full is allowed; count is unchanged.
- busy = (state == FEED) || pending != 0 || fifo_count != 0.

## Timing
- Reset values:
  - in_ready = 0 while rst is high, 1 the cycle after.
  - array_value = 0, array_index = 0, array_enable = 0.
  - out_valid = 0, out_result = 0, busy = 0, error = 0.
  - state = IDLE; idx, pending, spacing and FIFO pointers all 0.
- Reset mid-operation:
  - Aborts the vector and empties the FIFO; enable is low on the next cycle.
  - The cells have no reset, so stale results arriving afterwards hit pending == 0 and set error. This is expected and documented behaviour.
- Input → array latency: 1 cycle (array beat follows the handshake edge).
- Result → out_valid latency: 1 cycle after the edge on which array_result is flagged.
- Throughput: one element per cycle; a vector start at most every max(W, C) cycles; one result pop per cycle.
- Credit check uses registered fifo_count and pending values; it does not use a same-cycle pop (conservative).

## Test plan
- Reset test: hold rst 3 cycles with in_valid = 1 → in_ready = 0, array_enable = 0, out_valid = 0, error = 0, busy = 0; in_ready = 1 the first cycle after rst falls.
- Single vector (W=4, C=4): send 10, 20, 30, 40 back-to-back → array beats (10,0), (20,1), (30,2), (40,3) with enable high, each one cycle after its handshake; pending = 4. Then inject flagged results 100, 200, 300, 400 → out_result 100, 200, 300, 400 in order, pending = 0, busy falls.
- Backpressure (DEPTH=8): out_ready = 0, offer 3 vectors → the first two are accepted. in_ready stays low at element 0 of the third until results arrive and 4 are popped (fifo_count + pending ≤ 4), then it is accepted.
- Mid-vector gap: in_valid low for 2 cycles after element 1 → array_enable = 0 and array_index = 0 for those 2 cycles; the next element is issued with index 2.
- Spacing (W=2, C=4): continuous input → index-0 beats exactly 4 cycles apart, with in_ready low for 2 cycles between vectors.
- Error path: flagged result while pending = 0 → no FIFO push, error = 1 and it holds through further traffic until rst.
